// File: rtl/bsg_print_stat_pkg.sv
// Shared definitions for the print_stat event queue: tag kinds, kind field
// geometry, region FSM states and the {timestamp, tag} entry layout.

// Declares a packed entry struct holding a timestamp above a tag.
// Used inside modules so that the widths follow the module parameters.
`define BSG_PRINT_STAT_ENTRY_T(name, ts_w, tag_w) \
    typedef struct packed {                       \
        logic [(ts_w)-1:0]  ts;                   \
        logic [(tag_w)-1:0] tag;                  \
    } name;

package bsg_print_stat_pkg;

    // Kind field occupies the top bits of every tag.
    localparam int kind_width_lp = 2;

    typedef enum logic [kind_width_lp-1:0] {
        STAT  = 2'b00,
        START = 2'b01,
        END   = 2'b10,
        RSVD  = 2'b11
    } print_stat_kind_e;

    typedef enum logic {
        REGION_IDLE   = 1'b0,
        REGION_ACTIVE = 1'b1
    } region_state_e;

    // Lowest bit index of the kind field in a tag of the given width.
    function automatic int kind_lsb(input int tag_width);
        return tag_width - kind_width_lp;
    endfunction

endpackage

// File: rtl/bsg_print_stat_event_ring.sv
// Circular buffer of timestamped events with valid/yumi output.
// Full and empty are told apart by the occupancy register; pointers wrap.

module bsg_print_stat_event_ring
    import bsg_print_stat_pkg::*;
#(
    parameter int width_p = 96,
    parameter int els_p   = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       yumi_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int count_width_lp = $clog2(els_p+1);

    logic [width_p-1:0]        mem_r [els_p];
    logic [ptr_width_lp-1:0]   wptr_r;
    logic [ptr_width_lp-1:0]   rptr_r;
    logic [count_width_lp-1:0] count_r;
    logic                      pop;

    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rptr_r];
    assign count_o = count_r;

    // A yumi with nothing to pop is ignored so the ring state never corrupts.
    assign pop = yumi_i & v_o;

    // Storage write; contents need no reset because v_o gates them.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && v_i) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop leaves the count unchanged.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (v_i) begin
                wptr_r <= wptr_r + ptr_width_lp'(1);
            end
            if (pop) begin
                rptr_r <= rptr_r + ptr_width_lp'(1);
            end
            if (v_i && !pop) begin
                count_r <= count_r + count_width_lp'(1);
            end else if (!v_i && pop) begin
                count_r <= count_r - count_width_lp'(1);
            end
        end
    end

    // The host must never consume from an empty queue.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_o));
        end
    end

endmodule

// File: rtl/bsg_print_stat_event_queue.sv
// Timestamps snooped print_stat events into a small FIFO for the host,
// counts drops while full and tracks kernel start/end region balance.

module bsg_print_stat_event_queue
    import bsg_print_stat_pkg::*;
#(
    parameter int data_width_p     = 32,
    parameter int ctr_width_p      = 64,
    parameter int els_p            = 8,
    parameter int drop_ctr_width_p = 32
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                print_stat_v_i,
    input  logic [data_width_p-1:0]             print_stat_tag_i,
    input  logic [ctr_width_p-1:0]              global_ctr_i,
    output logic                                v_o,
    output logic [ctr_width_p+data_width_p-1:0] data_o,
    input  logic                                yumi_i,
    output logic [$clog2(els_p+1)-1:0]          count_o,
    output logic [drop_ctr_width_p-1:0]         drop_count_o,
    output logic                                overflow_o,
    output logic                                region_active_o,
    output logic                                region_err_o,
    input  logic                                clear_i
);

    `BSG_PRINT_STAT_ENTRY_T(entry_s, ctr_width_p, data_width_p)

    localparam int count_width_lp = $clog2(els_p+1);
    localparam int kind_lsb_lp    = kind_lsb(data_width_p);
    localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

    entry_s           wr_entry;
    logic             accept;
    logic             drop;
    logic             region_err_evt;
    print_stat_kind_e kind;
    region_state_e    region_state_r;

    assign wr_entry = '{ts: global_ctr_i, tag: print_stat_tag_i};
    assign kind     = print_stat_kind_e'(print_stat_tag_i[kind_lsb_lp +: kind_width_lp]);

    // A full queue still accepts when the host pops the head in the same cycle.
    assign accept = print_stat_v_i & ((count_o != full_count_lp) | yumi_i);
    assign drop   = print_stat_v_i & ~accept;

    assign region_err_evt = print_stat_v_i &
                            (((region_state_r == REGION_IDLE)   && (kind == END)) ||
                             ((region_state_r == REGION_ACTIVE) && (kind == START)));

    bsg_print_stat_event_ring #(
        .width_p (ctr_width_p + data_width_p),
        .els_p   (els_p)
    ) ring (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (accept),
        .data_i    (wr_entry),
        .yumi_i    (yumi_i),
        .v_o       (v_o),
        .data_o    (data_o),
        .count_o   (count_o)
    );

    // Saturating drop counter and sticky overflow; a drop outranks clear.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            drop_count_o <= '0;
            overflow_o   <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (clear_i) begin
                drop_count_o <= drop_ctr_width_p'(1);
            end else if (drop_count_o != '1) begin
                drop_count_o <= drop_count_o + drop_ctr_width_p'(1);
            end
        end else if (clear_i) begin
            drop_count_o <= '0;
            overflow_o   <= 1'b0;
        end
    end

    // Region FSM runs on every valid event, dropped or not; error is sticky.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            region_state_r  <= REGION_IDLE;
            region_active_o <= 1'b0;
            region_err_o    <= 1'b0;
        end else begin
            if (print_stat_v_i) begin
                if (kind == START) begin
                    region_state_r  <= REGION_ACTIVE;
                    region_active_o <= 1'b1;
                end else if (kind == END) begin
                    region_state_r  <= REGION_IDLE;
                    region_active_o <= 1'b0;
                end
            end
            if (region_err_evt) begin
                region_err_o <= 1'b1;
            end else if (clear_i) begin
                region_err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bsg_print_stat_event_queue.sv
// Scoreboard bench for the print_stat event queue: a queue-based model
// predicts each entry, a negedge monitor checks every popped entry and status.

module tb_bsg_print_stat_event_queue;

    localparam int DW   = 32;
    localparam int CW   = 64;
    localparam int ELS  = 8;
    localparam int DCW  = 4;
    localparam int DMAX = (1 << DCW) - 1;

    logic              clk = 1'b0;
    logic              reset_n_i = 1'b0;
    logic              print_stat_v_i = 1'b0;
    logic [DW-1:0]     print_stat_tag_i = '0;
    logic [CW-1:0]     global_ctr_i = '0;
    logic              v_o;
    logic [CW+DW-1:0]  data_o;
    logic              yumi_i = 1'b0;
    logic [3:0]        count_o;
    logic [DCW-1:0]    drop_count_o;
    logic              overflow_o;
    logic              region_active_o;
    logic              region_err_o;
    logic              clear_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [CW+DW-1:0] model_q[$];
    logic [CW+DW-1:0] sb_q[$];
    int               model_drop = 0;
    bit               model_ovf = 0;
    bit               model_err = 0;
    bit               model_active = 0;
    logic [CW-1:0]    next_ctr = '0;

    always #5 clk = ~clk;

    bsg_print_stat_event_queue #(
        .data_width_p     (DW),
        .ctr_width_p      (CW),
        .els_p            (ELS),
        .drop_ctr_width_p (DCW)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n_i),
        .print_stat_v_i   (print_stat_v_i),
        .print_stat_tag_i (print_stat_tag_i),
        .global_ctr_i     (global_ctr_i),
        .v_o              (v_o),
        .data_o           (data_o),
        .yumi_i           (yumi_i),
        .count_o          (count_o),
        .drop_count_o     (drop_count_o),
        .overflow_o       (overflow_o),
        .region_active_o  (region_active_o),
        .region_err_o     (region_err_o),
        .clear_i          (clear_i)
    );

    task automatic checkOutput(input string name, input logic [CW+DW-1:0] actual,
                               input logic [CW+DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs and returns 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] tag, input logic yumi,
                                 input logic clr, input logic rst_n);
        print_stat_v_i   = v;
        print_stat_tag_i = tag;
        yumi_i           = yumi;
        clear_i          = clr;
        reset_n_i        = rst_n;
        global_ctr_i     = next_ctr;
        next_ctr         = next_ctr + 1;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of entries plus counters and region bookkeeping.
    always @(posedge clk) begin : model
        bit       accept;
        bit       drop;
        bit       err_evt;
        bit [1:0] kind;
        if (!reset_n_i) begin
            model_q.delete();
            sb_q.delete();
            model_drop   = 0;
            model_ovf    = 0;
            model_err    = 0;
            model_active = 0;
        end else begin
            accept  = 0;
            drop    = 0;
            err_evt = 0;
            kind    = print_stat_tag_i[DW-1:DW-2];
            if (print_stat_v_i) begin
                accept = (model_q.size() < ELS) || yumi_i;
                drop   = !accept;
            end
            if (yumi_i && model_q.size() > 0) void'(model_q.pop_front());
            if (accept) begin
                model_q.push_back({global_ctr_i, print_stat_tag_i});
                sb_q.push_back({global_ctr_i, print_stat_tag_i});
            end
            if (print_stat_v_i) begin
                if (kind == 2'b01) begin
                    if (model_active) err_evt = 1;
                    model_active = 1;
                end else if (kind == 2'b10) begin
                    if (!model_active) err_evt = 1;
                    model_active = 0;
                end
            end
            if (drop) begin
                model_ovf  = 1;
                model_drop = clear_i ? 1 : ((model_drop >= DMAX) ? DMAX : model_drop + 1);
            end else if (clear_i) begin
                model_ovf  = 0;
                model_drop = 0;
            end
            if (err_evt) model_err = 1;
            else if (clear_i) model_err = 0;
        end
    end

    // Monitor: status every cycle, and each entry the host consumes.
    always @(negedge clk) begin
        logic [CW+DW-1:0] exp_entry;
        checkOutput("v_o", v_o, model_q.size() != 0);
        checkOutput("count_o", count_o, model_q.size());
        checkOutput("drop_count_o", drop_count_o, model_drop);
        checkOutput("overflow_o", overflow_o, model_ovf);
        checkOutput("region_active_o", region_active_o, model_active);
        checkOutput("region_err_o", region_err_o, model_err);
        if (v_o && yumi_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL pop_unexpected actual=%0h required=none", data_o);
            end else begin
                exp_entry = sb_q.pop_front();
                checkOutput("data_o", data_o, exp_entry);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset
        applyStimulus(0, '0, 0, 0, 0);
        applyStimulus(1, 32'h4000_0009, 0, 0, 0);
        checkOutput("reset_v", v_o, 0);
        checkOutput("reset_count", count_o, 0);
        applyStimulus(0, '0, 0, 0, 1);

        // Three events at counters 100..102
        next_ctr = 100;
        applyStimulus(1, 32'h4000_0001, 0, 0, 1);
        checkOutput("active_after_start", region_active_o, 1);
        applyStimulus(1, 32'h0000_0005, 0, 0, 1);
        applyStimulus(1, 32'h8000_0001, 0, 0, 1);
        checkOutput("active_after_end", region_active_o, 0);
        checkOutput("count_three", count_o, 3);
        checkOutput("head_first", data_o, {64'd100, 32'h4000_0001});
        for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 0, 1);
        checkOutput("no_region_err", region_err_o, 0);

        // Overfill with 11 STAT events
        for (int i = 0; i < 11; i++) applyStimulus(1, DW'(i), 0, 0, 1);
        checkOutput("full_count", count_o, 8);
        checkOutput("three_drops", drop_count_o, 3);
        checkOutput("overflow_set", overflow_o, 1);

        // Push while full with a same-cycle pop
        applyStimulus(1, 32'h0000_00AA, 1, 0, 1);
        checkOutput("full_push_pop_count", count_o, 8);
        checkOutput("full_push_pop_drops", drop_count_o, 3);
        for (int i = 0; i < 7; i++) applyStimulus(0, '0, 1, 0, 1);
        checkOutput("last_entry", data_o[DW-1:0], 32'h0000_00AA);
        applyStimulus(0, '0, 1, 0, 1);

        // Unbalanced END, then clear alone
        applyStimulus(1, 32'h0000_0007, 0, 0, 1);
        applyStimulus(1, 32'h8000_0002, 0, 0, 1);
        checkOutput("end_without_start", region_err_o, 1);
        applyStimulus(0, '0, 0, 1, 1);
        checkOutput("clear_err", region_err_o, 0);
        checkOutput("clear_keeps_fifo", count_o, 2);

        // Drop and clear in the same cycle
        for (int i = 0; i < 6; i++) applyStimulus(1, DW'(32'h100 + i), 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h0000_0200, 0, 0, 1);
        checkOutput("five_drops", drop_count_o, 5);
        applyStimulus(1, 32'h0000_0201, 0, 1, 1);
        checkOutput("drop_beats_clear", drop_count_o, 1);
        checkOutput("drop_beats_clear_ovf", overflow_o, 1);

        // Saturation of the drop counter
        applyStimulus(0, '0, 0, 1, 1);
        for (int i = 0; i < 15; i++) applyStimulus(1, 32'h0000_0300, 0, 0, 1);
        checkOutput("drops_at_max", drop_count_o, 15);
        for (int i = 0; i < 2; i++) applyStimulus(1, 32'h0000_0301, 0, 0, 1);
        checkOutput("drops_saturated", drop_count_o, 15);

        // Reset mid-stream with four entries queued
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 0, 1);
        applyStimulus(1, 32'h4000_0042, 0, 0, 1);
        checkOutput("four_queued", count_o, 4);
        applyStimulus(1, 32'h8000_0042, 1, 0, 0);
        checkOutput("midreset_v", v_o, 0);
        checkOutput("midreset_count", count_o, 0);
        checkOutput("midreset_drops", drop_count_o, 0);
        checkOutput("midreset_ovf", overflow_o, 0);
        checkOutput("midreset_active", region_active_o, 0);
        checkOutput("midreset_err", region_err_o, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [DW-1:0] tag;
            tag = {2'($urandom_range(0, 3)), 30'($urandom)};
            applyStimulus($urandom_range(0, 99) < 60, tag,
                          (model_q.size() > 0) && ($urandom_range(0, 1) == 1),
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 299) != 0);
        end

        // Drain what is left
        for (int i = 0; i < 2 * ELS; i++) begin
            applyStimulus(0, '0, model_q.size() > 0, 0, 1);
        end
        checkOutput("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_print_stat_event_queue.md
Name: bsg_print_stat_event_queue

Overview:
- Downstream consumer of the print-stat snoop output and the global cycle counter in the bigblade-vcs DPI top.
- Timestamps every snooped print_stat event with the global counter value and buffers it in a small FIFO that the C/C++ host drains over DPI.
- Tracks kernel start/end region balance.
- Reports dropped events and protocol errors so that cosim can fail loudly instead of silently losing profile markers.

Parameters:
- data_width_p, 32: width of the print_stat tag (equals NoC data width).
- ctr_width_p, 64: width of the global cycle counter.
- els_p, 8: FIFO depth. Must be a power of 2 and >= 2.
- drop_ctr_width_p, 32: width of the saturating drop counter.

Ports:
- clk_i, in, 1: core clock.
- reset_n_i, in, 1: synchronous reset, active-low.
- print_stat_v_i, in, 1: snooped print_stat event valid (single-cycle pulse per event).
- print_stat_tag_i, in, data_width_p: event tag.
- global_ctr_i, in, ctr_width_p: free-running global cycle counter.
- v_o, out, 1: head entry valid.
- data_o, out, ctr_width_p+data_width_p: head entry {timestamp, tag}, timestamp in the MSBs.
- yumi_i, in, 1: host consumes head entry this cycle.
- count_o, out, $clog2(els_p+1): current occupancy.
- drop_count_o, out, drop_ctr_width_p: events dropped while full. Saturating.
- overflow_o, out, 1: sticky; set on any drop.
- region_active_o, out, 1: high between a start tag and its end tag.
- region_err_o, out, 1: sticky; unbalanced start/end seen.
- clear_i, in, 1: synchronous clear of drop_count_o, overflow_o and region_err_o.

Behaviour:
- Reset (reset_n_i=0 at posedge): v_o=0, count_o=0, drop_count_o=0, overflow_o=0, region_active_o=0, region_err_o=0. Pointers are zeroed. Any in-flight event in the reset cycle is discarded. data_o contents are don't-care while v_o=0.
- Tag kind field is tag[data_width_p-1 -: 2]:
  - 00 = STAT
  - 01 = START
  - 10 = END
  - 11 = RSVD, enqueued as-is with no region effect.
- Enqueue: when print_stat_v_i=1 and the entry is accepted, {global_ctr_i, print_stat_tag_i} sampled in that same cycle is written at the posedge.
  - v_o/count_o reflect the entry the next cycle (latency 1). There is no combinational bypass.
- Dequeue: when yumi_i=1, the head entry is popped at the posedge and data_o shows the next entry the following cycle.
  - yumi_i while v_o=0 is illegal: assertion fires and state is unchanged.
- Acceptance: the entry is accepted if count_o<els_p, OR if count_o==els_p and yumi_i=1 (pop and push in the same cycle; count unchanged).
- Simultaneous push and pop at any occupancy: count_o unchanged, FIFO order preserved.
- Drop: v=1 while full and yumi_i=0. The entry is discarded, drop_count_o increments (holds at all-ones) and overflow_o is set.
- Pointers are log2(els_p) bits and wrap naturally. Full/empty are distinguished by the count register.
- Region FSM has two states, IDLE and ACTIVE. It is evaluated on every valid event, including dropped ones.
  - IDLE + START -> ACTIVE.
  - IDLE + END -> IDLE, region_err_o set.
  - ACTIVE + END -> IDLE.
  - ACTIVE + START -> ACTIVE, region_err_o set.
  - STAT/RSVD cause no transition.
  - region_active_o=1 in ACTIVE, registered, so it changes the cycle after the event.
- clear_i: resets drop_count_o, overflow_o and region_err_o at the posedge. It does not touch the FIFO or the FSM.
  - If clear_i and a drop or error occur in the same cycle, the event wins: drop_count_o=1, overflow_o=1, and region_err_o=1 if that event is itself an error.
- The timestamp is the raw counter value. Counter wrap is not detected.

Decomposition:
- Package bsg_print_stat_pkg holds:
  - enum print_stat_kind_e {STAT, START, END, RSVD};
  - kind field offset/width localparams;
  - a packed struct for the entry {ts, tag} parameterised via macro.
- Sub-module bsg_print_stat_event_ring holds the storage array plus read/write pointers and count, with a valid/yumi output.
- The top module holds the accept/drop logic, drop counter, sticky flags and region FSM.

Test Plan:
- Reset, then 3 events (tags 0x4000_0001 START, 0x0000_0005 STAT, 0x8000_0001 END) at ctr 100/101/102 -> entries {100,0x40000001},{101,5},{102,0x80000001} in order; region_active_o goes 1 at cycle 101 and 0 at cycle 103; region_err_o=0.
- els_p=8, yumi_i=0, 11 back-to-back STAT events -> count_o=8, drop_count_o=3, overflow_o=1; first 8 tags are drained intact.
- Full FIFO, event with yumi_i=1 same cycle -> accepted, count_o stays 8, drop_count_o unchanged; the new entry appears last after 8 pops.
- END with no START -> region_err_o=1 next cycle, region_active_o=0; clear_i alone -> region_err_o=0, FIFO contents untouched.
- clear_i asserted in the same cycle as a drop with drop_count_o=5 -> drop_count_o=1, overflow_o=1.
- drop_count_o forced near saturation (drop_ctr_width_p=4: 15 drops then 2 more) -> holds at 15. Pulse reset_n_i=0 mid-stream with 4 entries queued -> v_o=0, count_o=0, all flags 0 next cycle.
